int32_to_ascii: RTL and testbench

INT32_TO_ASCII -- requirements
Module: int32_to_ascii

---
 rtl/int32_to_ascii.sv | 148 ++++++++++++++
 tb/tb_int32_to_ascii.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/int32_to_ascii.sv
// rtl/int32_to_ascii.sv - signed 32-bit integer to ASCII decimal character stream
module int32_to_ascii #(
  parameter int         APPEND_SEP = 1,
  parameter logic [7:0] SEP_CHAR   = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        num_end,
  output logic        done
);

  localparam logic SEP_EN = (APPEND_SEP != 0);

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    EMIT_SIGN,
    EMIT_DIGIT,
    EMIT_SEP,
    FINISH
  } state_t;

  state_t      state;
  logic [31:0] mag;
  logic [31:0] mag_div;
  logic [3:0]  mag_rem;
  logic        is_neg;
  logic        conv_last;
  logic [3:0]  count;
  logic [3:0]  idx;
  logic [3:0]  digits [10];
  logic        hs;

  assign mag_div = mag / 32'd10;
  assign mag_rem = 4'(mag % 32'd10);
  assign hs      = char_valid & char_ready;
  assign busy    = (state != IDLE);

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mag        <= '0;
      is_neg     <= 1'b0;
      conv_last  <= 1'b0;
      count      <= '0;
      idx        <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
      num_end    <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < 10; i++) digits[i] <= '0;
    end else if (clear) begin
      state      <= IDLE;
      char_out   <= '0;
      char_valid <= 1'b0;
      num_end    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_neg    <= value[31];
            mag       <= value[31] ? (~value + 32'd1) : value;
            count     <= '0;
            conv_last <= 1'b0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          // Exit flag is registered so the divider stays out of the state-decision path.
          if (conv_last) begin
            idx        <= count - 4'd1;
            char_valid <= 1'b1;
            if (is_neg) begin
              state    <= EMIT_SIGN;
              char_out <= 8'h2D;
              num_end  <= 1'b0;
            end else begin
              state    <= EMIT_DIGIT;
              char_out <= digit_char(digits[count - 4'd1]);
              num_end  <= !SEP_EN && (count == 4'd1);
            end
          end else begin
            digits[count] <= mag_rem;
            count         <= count + 4'd1;
            mag           <= mag_div;
            conv_last     <= (mag_div == 32'd0);
          end
        end
        EMIT_SIGN: begin
          if (hs) begin
            state    <= EMIT_DIGIT;
            char_out <= digit_char(digits[idx]);
            num_end  <= !SEP_EN && (idx == 4'd0);
          end
        end
        EMIT_DIGIT: begin
          if (hs) begin
            if (idx == 4'd0) begin
              if (SEP_EN) begin
                state    <= EMIT_SEP;
                char_out <= SEP_CHAR;
                num_end  <= 1'b1;
              end else begin
                state      <= FINISH;
                char_out   <= '0;
                char_valid <= 1'b0;
                num_end    <= 1'b0;
                done       <= 1'b1;
              end
            end else begin
              idx      <= idx - 4'd1;
              char_out <= digit_char(digits[idx - 4'd1]);
              num_end  <= !SEP_EN && (idx == 4'd1);
            end
          end
        end
        EMIT_SEP: begin
          if (hs) begin
            state      <= FINISH;
            char_out   <= '0;
            char_valid <= 1'b0;
            num_end    <= 1'b0;
            done       <= 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int32_to_ascii.sv
// tb/tb_int32_to_ascii.sv - directed self-checking bench for int32_to_ascii
module tb_int32_to_ascii;

  logic        clk = 1'b0;
  logic        rst_n, clear, start, start0, char_ready;
  logic [31:0] value, value0;
  logic        busy, char_valid, num_end, done;
  logic [7:0]  char_out;
  logic        busy0, char_valid0, num_end0, done0;
  logic [7:0]  char_out0;

  int          checks = 0;
  int          failures = 0;
  logic [8:0]  got[$];
  logic [8:0]  got0[$];
  logic        stall;
  logic [8:0]  stall_val;
  logic        seen;
  int          n;

  always #5 clk = ~clk;

  int32_to_ascii dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .value(value),
    .busy(busy), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .num_end(num_end), .done(done)
  );

  int32_to_ascii #(.APPEND_SEP(0), .SEP_CHAR(8'h20)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start0), .value(value0),
    .busy(busy0), .char_out(char_out0), .char_valid(char_valid0),
    .char_ready(char_ready), .num_end(num_end0), .done(done0)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are settled here, so a valid&ready seen now is the handshake of the coming edge.
  task automatic tick();
    if (rst_n && !clear && char_valid && char_ready) got.push_back({num_end, char_out});
    if (rst_n && !clear && char_valid0 && char_ready) got0.push_back({num_end0, char_out0});
    stall     = rst_n && !clear && char_valid && !char_ready;
    stall_val = {num_end, char_out};
    @(negedge clk);
    if (stall) begin
      chk(32'(char_valid), 32'd1, "hold_valid");
      chk(32'({num_end, char_out}), 32'(stall_val), "hold_data");
    end
  endtask

  task automatic send(input logic [31:0] v);
    got.delete();
    start = 1'b1;
    value = v;
    tick();
    start = 1'b0;
    value = 32'h1234_5678;
  endtask

  task automatic wait_done(input bit toggle, input string tag);
    int k = 0;
    while (!done && k < 200) begin
      if (toggle) char_ready = ~char_ready;
      tick();
      k++;
    end
    chk(32'(done), 32'd1, {tag, "_done"});
    char_ready = 1'b1;
  endtask

  task automatic check_seq(input bit which, input string exp, input string tag);
    int sz;
    logic [8:0] e;
    logic [8:0] a;
    sz = which ? got0.size() : got.size();
    chk(32'(sz), 32'(exp.len()), {tag, "_len"});
    for (int i = 0; i < exp.len() && i < sz; i++) begin
      e = {(i == exp.len() - 1), exp[i]};
      a = which ? got0[i] : got[i];
      chk(32'(a), 32'(e), $sformatf("%s_char%0d", tag, i));
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; start0 = 1'b0;
    value = '0; value0 = '0; char_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(char_valid), 32'd0, "rst_valid");
    chk(32'(char_out), 32'h00, "rst_char");
    chk(32'(num_end), 32'd0, "rst_num_end");
    chk(32'(done), 32'd0, "rst_done");
    chk(32'(busy0), 32'd0, "rst_busy0");
    rst_n = 1'b1;
    tick();

    // value 0: one digit, first valid after edge D+1 = 2
    send(32'd0);
    tick();
    chk(32'(char_valid), 32'd0, "lat0_edge1");
    chk(32'(busy), 32'd1, "lat0_busy");
    tick();
    chk(32'(char_valid), 32'd1, "lat0_edge2");
    chk(32'(char_out), 32'h30, "lat0_char");
    wait_done(1'b0, "zero");
    check_seq(1'b0, "0 ", "zero");
    tick();
    chk(32'(done), 32'd0, "zero_done_pulse");
    chk(32'(busy), 32'd0, "zero_idle");

    // -123 with a start pulse ignored while busy
    send(-32'sd123);
    tick();
    start = 1'b1; value = 32'd999;
    tick();
    start = 1'b0;
    wait_done(1'b0, "neg123");
    check_seq(1'b0, "-123 ", "neg123");
    tick();

    // ten digits: first valid after edge 11
    send(32'd2147483647);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (char_valid) seen = 1'b1;
    end
    chk(32'(seen), 32'd0, "lat10_early");
    tick();
    chk(32'(char_valid), 32'd1, "lat10_edge11");
    wait_done(1'b0, "maxpos");
    check_seq(1'b0, "2147483647 ", "maxpos");
    tick();

    send(32'h8000_0000);
    wait_done(1'b0, "minneg");
    check_seq(1'b0, "-2147483648 ", "minneg");
    tick();

    // backpressure: char_ready toggles every cycle
    send(32'd45);
    wait_done(1'b1, "stall45");
    check_seq(1'b0, "45 ", "stall45");
    tick();

    // clear after the second handshake of -123
    send(-32'sd123);
    n = 0;
    while (got.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    chk(32'(got.size()), 32'd2, "clr_two_hs");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk(32'(char_valid), 32'd0, "clr_valid");
    chk(32'(num_end), 32'd0, "clr_num_end");
    chk(32'(busy), 32'd0, "clr_busy");
    seen = done;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || char_valid) seen = 1'b1;
    end
    chk(32'(seen), 32'd0, "clr_no_done");
    send(32'd7);
    wait_done(1'b0, "after_clr");
    check_seq(1'b0, "7 ", "after_clr");
    tick();

    // asynchronous reset mid-number
    send(32'd2147483647);
    n = 0;
    while (got.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk(32'(char_valid), 32'd0, "arst_valid");
    chk(32'(busy), 32'd0, "arst_busy");
    chk(32'(char_out), 32'h00, "arst_char");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk(32'(busy), 32'd0, "arst_waits");
    chk(32'(got.size()), 32'd3, "arst_no_more");

    // no separator instance: -9, starts during busy and FINISH ignored
    got0.delete();
    start0 = 1'b1; value0 = -32'sd9;
    tick();
    start0 = 1'b0; value0 = 32'd0;
    tick();
    start0 = 1'b1; value0 = 32'd5;
    tick();
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 50) begin
      tick();
      n++;
    end
    chk(32'(done0), 32'd1, "nosep_done");
    start0 = 1'b1; value0 = 32'd3;
    tick();
    start0 = 1'b0;
    chk(32'(busy0), 32'd0, "nosep_finish_start");
    chk(32'(done0), 32'd0, "nosep_done_pulse");
    check_seq(1'b1, "-9", "nosep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
